// File: rtl/rr_log_arbiter_pkg.sv
// Shared types and widths for the round-robin record-log arbiter.
package rr_log_arbiter_pkg;

   localparam int RR_SEQ_W = 16;
   localparam int RR_SID_W = 2;
   localparam int RR_PKT_W = 128;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      RUN      = 2'd1,
      DRAIN    = 2'd2
   } rr_log_state_e;

   typedef struct packed {
      logic [RR_SEQ_W-1:0] seq;
      logic [RR_SID_W-1:0] src_id;
      logic [RR_PKT_W-1:0] payload;
   } rr_log_pkt_t;

   // Source-ID width never drops below one bit, even for two sources.
   function automatic int sid_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_log_arbiter_if.sv
// Recorder-side and log-side streams plus session control of the log arbiter.
interface rr_log_arbiter_if
   import rr_log_arbiter_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int PKT_W = 128,
   parameter int SEQ_W = 16,
   parameter int CNT_W = 32
);
   localparam int SID_W = sid_width(N_SRC);
   localparam int LOG_W = SEQ_W + SID_W + PKT_W;

   logic [N_SRC-1:0]       src_valid;
   logic [N_SRC-1:0]       src_ready;
   logic [N_SRC*PKT_W-1:0] src_data;
   logic                   log_valid;
   logic                   log_ready;
   logic [LOG_W-1:0]       log_data;
   logic                   rec_enable;
   logic                   drain_done;
   logic                   busy;
   logic [CNT_W-1:0]       discard_cnt;

   modport slave (
      input  src_valid, src_data, log_ready, rec_enable,
      output src_ready, log_valid, log_data, drain_done, busy, discard_cnt
   );

   modport master (
      output src_valid, src_data, log_ready, rec_enable,
      input  src_ready, log_valid, log_data, drain_done, busy, discard_cnt
   );
endinterface

// File: rtl/rr_log_arbiter_rr_pick.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      any       = |req;
      // Scan farthest-first so the nearest requester at or after ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end
endmodule

// File: rtl/rr_log_arbiter.sv
// Round-robin merge of recorder streams into one tagged log stream; 1-cycle latency.
// One-entry output register holds while log_ready is low; sources are stalled meanwhile.
module rr_log_arbiter
   import rr_log_arbiter_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int PKT_W = 128,
   parameter int SEQ_W = 16,
   parameter int CNT_W = 32
) (
   input logic            clk,
   input logic            rst_n,
   rr_log_arbiter_if.slave bus
);
   localparam int SID_W = sid_width(N_SRC);
   localparam int LOG_W = SEQ_W + SID_W + PKT_W;
   localparam int PC_W  = $clog2(N_SRC + 1);

   rr_log_state_e     state;
   logic [SEQ_W-1:0]  seq;
   logic [SID_W-1:0]  rr_ptr;
   logic              log_valid_q;
   logic [LOG_W-1:0]  log_data_q;
   logic              drain_done_q;
   logic [CNT_W-1:0]  discard_q;

   logic [N_SRC-1:0]  grant;
   logic [SID_W-1:0]  grant_idx;
   logic              any_req;
   logic              load_en;
   logic              accept;
   logic [PKT_W-1:0]  pick_data;
   logic [SID_W-1:0]  next_ptr;
   logic [PC_W-1:0]   n_valid;
   logic [CNT_W:0]    cnt_sum;
   logic [CNT_W-1:0]  discard_nxt;
   logic [N_SRC-1:0]  src_ready;

   rr_rr_pick #(.N(N_SRC), .IDX_W(SID_W)) u_pick (
      .req       (bus.src_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   assign load_en   = !log_valid_q || bus.log_ready;
   assign accept    = (state == RUN) && any_req && load_en;
   assign pick_data = bus.src_data[grant_idx*PKT_W +: PKT_W];
   assign next_ptr  = (grant_idx == SID_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      n_valid = '0;
      for (int i = 0; i < N_SRC; i++) n_valid = n_valid + PC_W'(bus.src_valid[i]);
      cnt_sum     = {1'b0, discard_q} + (CNT_W + 1)'(n_valid);
      discard_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   // While disabled every source is drained so recorders never back up.
   always_comb begin
      src_ready = '0;
      case (state)
         DISABLED: src_ready = '1;
         RUN:      src_ready = grant & {N_SRC{load_en}};
         default:  src_ready = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= DISABLED;
         seq          <= '0;
         rr_ptr       <= '0;
         log_valid_q  <= 1'b0;
         log_data_q   <= '0;
         drain_done_q <= 1'b0;
         discard_q    <= '0;
      end else begin
         drain_done_q <= 1'b0;
         if (load_en) begin
            log_valid_q <= accept;
            if (accept) log_data_q <= {seq, grant_idx, pick_data};
         end
         case (state)
            DISABLED: begin
               discard_q <= discard_nxt;
               if (bus.rec_enable) begin
                  state  <= RUN;
                  seq    <= '0;
                  rr_ptr <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  rr_ptr <= next_ptr;
                  seq    <= seq + 1'b1;
               end
               if (!bus.rec_enable) state <= DRAIN;
            end
            DRAIN: begin
               // Output register is empty or empties this cycle.
               if (load_en) begin
                  state        <= DISABLED;
                  drain_done_q <= 1'b1;
               end
            end
            default: state <= DISABLED;
         endcase
      end
   end

   assign bus.src_ready   = src_ready;
   assign bus.log_valid   = log_valid_q;
   assign bus.log_data    = log_data_q;
   assign bus.drain_done  = drain_done_q;
   assign bus.busy        = (state != DISABLED);
   assign bus.discard_cnt = discard_q;

endmodule

// File: tb/tb_rr_log_arbiter.sv
// Directed bench: grant order, backpressure, seq wrap, drain, discard saturation, async reset.
module tb_rr_log_arbiter;
   localparam int N_SRC = 4;
   localparam int PKT_W = 16;
   localparam int SEQ_W = 4;
   localparam int CNT_W = 5;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [PKT_W-1:0] pkt [N_SRC];

   rr_log_arbiter_if #(.N_SRC(N_SRC), .PKT_W(PKT_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) bus ();

   rr_log_arbiter #(.N_SRC(N_SRC), .PKT_W(PKT_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [21:0] exp_pkt(input int s, input int id);
      return {4'(s % 16), 2'(id), pkt[id]};
   endfunction

   initial begin
      pkt[0] = 16'hA0A0;
      pkt[1] = 16'hB1B1;
      pkt[2] = 16'hC2C2;
      pkt[3] = 16'hD3D3;
      rst_n          = 1'b0;
      bus.src_valid  = '0;
      bus.src_data   = {pkt[3], pkt[2], pkt[1], pkt[0]};
      bus.log_ready  = 1'b1;
      bus.rec_enable = 1'b0;
      #1;
      check("rst_log_valid", 64'(bus.log_valid), 64'd0);
      check("rst_log_data", 64'(bus.log_data), 64'd0);
      check("rst_src_ready", 64'(bus.src_ready), 64'hF);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_drain_done", 64'(bus.drain_done), 64'd0);
      check("rst_discard", 64'(bus.discard_cnt), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Enable and send a single packet twice from source 0.
      bus.rec_enable = 1'b1;
      tick();
      check("run_busy", 64'(bus.busy), 64'd1);
      bus.src_valid = 4'b0001;
      #1 check("single_ready", 64'(bus.src_ready), 64'h1);
      tick();
      check("single_valid", 64'(bus.log_valid), 64'd1);
      check("single_data0", 64'(bus.log_data), 64'(exp_pkt(0, 0)));
      tick();
      check("single_data1", 64'(bus.log_data), 64'(exp_pkt(1, 0)));
      bus.src_valid = 4'b0000;
      tick();
      check("idle_valid", 64'(bus.log_valid), 64'd0);

      // Stop on an empty register, then restart to reset seq and pointer.
      bus.rec_enable = 1'b0;
      tick();
      check("drain_busy", 64'(bus.busy), 64'd1);
      tick();
      check("drain_empty_done", 64'(bus.drain_done), 64'd1);
      check("drain_empty_busy", 64'(bus.busy), 64'd0);
      bus.rec_enable = 1'b1;
      tick();
      check("rerun_busy", 64'(bus.busy), 64'd1);
      check("rerun_done_low", 64'(bus.drain_done), 64'd0);

      // All sources requesting: strict rotation, one packet per cycle.
      bus.src_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1 check("rot_ready", 64'(bus.src_ready), 64'(1 << (k % 4)));
         tick();
         check("rot_valid", 64'(bus.log_valid), 64'd1);
         check("rot_data", 64'(bus.log_data), 64'(exp_pkt(k, k % 4)));
      end

      // Backpressure holds the register and stalls every source.
      bus.log_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1 check("bp_ready", 64'(bus.src_ready), 64'h0);
         tick();
         check("bp_hold", 64'(bus.log_data), 64'(exp_pkt(7, 3)));
      end
      bus.log_ready = 1'b1;
      #1 check("bp_resume_ready", 64'(bus.src_ready), 64'h1);
      tick();
      check("bp_resume0", 64'(bus.log_data), 64'(exp_pkt(8, 0)));
      tick();
      check("bp_resume1", 64'(bus.log_data), 64'(exp_pkt(9, 1)));

      // Sequence number wraps 15 -> 0 with a 4-bit counter.
      for (int k = 0; k < 8; k++) begin
         tick();
         check("wrap_data", 64'(bus.log_data), 64'(exp_pkt(10 + k, (2 + k) % 4)));
      end
      bus.src_valid = 4'b0000;
      tick();
      check("wrap_idle", 64'(bus.log_valid), 64'd0);

      // Drain with a packet held under backpressure.
      bus.src_valid = 4'b0001;
      tick();
      check("hold_pkt", 64'(bus.log_data), 64'(exp_pkt(2, 0)));
      bus.log_ready  = 1'b0;
      bus.rec_enable = 1'b0;
      bus.src_valid  = 4'b0000;
      tick();
      check("drain_hold_busy", 64'(bus.busy), 64'd1);
      check("drain_hold_valid", 64'(bus.log_valid), 64'd1);
      check("drain_hold_data", 64'(bus.log_data), 64'(exp_pkt(2, 0)));
      bus.src_valid = 4'b1111;
      #1 check("drain_ready", 64'(bus.src_ready), 64'h0);
      tick();
      check("drain_wait_done", 64'(bus.drain_done), 64'd0);
      check("drain_wait_valid", 64'(bus.log_valid), 64'd1);
      bus.src_valid = 4'b0000;
      bus.log_ready = 1'b1;
      tick();
      check("drain_done_pulse", 64'(bus.drain_done), 64'd1);
      check("drain_out_empty", 64'(bus.log_valid), 64'd0);
      check("drain_idle_busy", 64'(bus.busy), 64'd0);
      tick();
      check("drain_done_once", 64'(bus.drain_done), 64'd0);

      // Disabled: drop everything and count, saturating at 31.
      bus.src_valid = 4'b0111;
      #1 check("dis_ready", 64'(bus.src_ready), 64'hF);
      repeat (10) tick();
      check("dis_count30", 64'(bus.discard_cnt), 64'd30);
      check("dis_no_valid", 64'(bus.log_valid), 64'd0);
      tick();
      check("dis_sat", 64'(bus.discard_cnt), 64'd31);
      tick();
      check("dis_sat_hold", 64'(bus.discard_cnt), 64'd31);

      // Re-enable, hold a packet, then reset asynchronously mid-cycle.
      bus.src_valid  = 4'b0000;
      bus.rec_enable = 1'b1;
      tick();
      check("re_en_busy", 64'(bus.busy), 64'd1);
      check("re_en_discard_kept", 64'(bus.discard_cnt), 64'd31);
      bus.src_valid = 4'b0010;
      bus.log_ready = 1'b0;
      tick();
      check("re_en_pkt", 64'(bus.log_data), 64'(exp_pkt(0, 1)));
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(bus.log_valid), 64'd0);
      check("arst_data", 64'(bus.log_data), 64'd0);
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_ready", 64'(bus.src_ready), 64'hF);
      check("arst_discard", 64'(bus.discard_cnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_log_arbiter.md
Name: rr_log_arbiter

Overview:
- Shares one record-log output stream among N_SRC recorder packet streams, e.g. several axil/axi master recorder rec_out buses.
- Arbitrates round-robin and tags each granted packet with a source ID and a global sequence number.
- Holds each packet in a one-entry output register until the log writer accepts it.
- Runs a recording-session FSM (DISABLED/RUN/DRAIN) so software can start and stop logging cleanly.

Parameters:
N_SRC, 4, number of recorder streams (2..8)
PKT_W, 128, width of one recorder packet (header + channel payloads)
SEQ_W, 16, sequence number width
CNT_W, 32, width of the discarded-packet counter

Ports:
clk  in  1  clock
rst_n  in  1  reset
src_valid  in  N_SRC  per-source packet valid
src_ready  out  N_SRC  per-source packet accept
src_data  in  N_SRC*PKT_W  packets; source i occupies [i*PKT_W +: PKT_W]
log_valid  out  1  output packet valid
log_ready  in  1  log writer ready
log_data  out  SEQ_W+SID_W+PKT_W  {seq, src_id, payload}
rec_enable  in  1  level; 1 = record, 0 = stop
drain_done  out  1  one-cycle pulse when DRAIN completes
busy  out  1  1 in RUN or DRAIN
discard_cnt  out  CNT_W  packets discarded while DISABLED, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=DISABLED, src_ready=all 1, log_valid=0, log_data=0, seq=0, rr_ptr=0, drain_done=0, busy=0, discard_cnt=0.
- SID_W = max(1, $clog2(N_SRC)).
- Output register:
  - load_en = !log_valid || log_ready.
  - log_data/log_valid change only when load_en=1, so data stays stable while log_valid && !log_ready.
  - A load and an output handshake in the same cycle are allowed, giving full throughput of 1 packet/cycle.
- Arbitration (RUN only):
  - Grant goes to the first src_valid[i] at or after rr_ptr, scanning upward and wrapping modulo N_SRC.
  - src_ready[i] = grant[i] && load_en; it is combinational from src_valid by design, and the recorders tolerate this.
  - On accept of source i: rr_ptr <= (i+1) mod N_SRC, log_data <= {seq, i, src_data_i}, log_valid <= 1, seq <= seq+1 (wraps 2^SEQ_W-1 -> 0).
  - Latency is 1 cycle from src handshake to log_valid.
  - No source valid and log_ready=1: log_valid <= 0.
  - A source holding valid is granted within N_SRC accepts, so no starvation.
- DISABLED:
  - src_ready=all 1, and every valid packet is dropped.
  - discard_cnt += popcount(src_valid) each cycle, saturating at 2^CNT_W-1.
  - rec_enable=1 -> RUN; seq <= 0 and rr_ptr <= 0 on that transition. discard_cnt is not cleared.
- RUN:
  - Arbitration as above.
  - rec_enable=0 -> DRAIN. A packet accepted in the same cycle as the transition is kept.
- DRAIN:
  - src_ready=all 0.
  - When the output register is empty (log_valid=0), or emptying this cycle (log_valid && log_ready): next state DISABLED and drain_done=1 for one cycle.
  - rec_enable returning to 1 during DRAIN does not abort the drain. The FSM goes to DISABLED, then to RUN the next cycle.
- busy = (state != DISABLED).
- Asynchronous reset mid-packet drops the held packet; all outputs return to reset values immediately.

Decomposition:
- Shared package (cl_fpgarr_types.svh):
  - typedef rr_log_pkt_t as a packed struct {seq, src_id, payload}.
  - constants RR_SEQ_W, RR_SID_W.
  - enum rr_log_state_e {DISABLED, RUN, DRAIN}.
- Sub-module rr_rr_pick: purely combinational round-robin pick with inputs req[N], ptr and outputs grant onehot, grant_idx, any.

Test Plan:
- Reset, then rec_enable=1, src_valid=4'b0001 with data A, log_ready=1 -> log_valid next cycle, log_data={0,0,A}; seq 1 on the next packet.
- src_valid=4'b1111 held for 8 cycles, log_ready=1 -> grant order 0,1,2,3,0,1,2,3; seq 0..7; one packet/cycle.
- log_ready=0 for 5 cycles with log_valid=1 -> log_data stable, all src_ready=0, no seq increment; log_ready=1 -> resumes with no loss or duplication.
- Disabled, src_valid=4'b0111 for 10 cycles -> src_ready=1111, discard_cnt=30, log_valid=0.
- RUN with a packet held (log_ready=0), rec_enable->0 -> DRAIN with src_ready=0; log_ready=1 -> drain_done pulses once, state DISABLED.
- SEQ_W=4, 20 packets -> seq wraps 15 -> 0. Assert rst_n low with log_valid=1 -> log_valid=0 immediately.
